// File: rtl/oneshot_pkg.sv
// Shared types and helpers for the one-shot pulse arbiter.
package oneshot_pkg;

    // Largest supported requester count and the index width that covers it.
    localparam int MAX_CH = 16;
    localparam int IDX_W  = 4;
    // One extra bit so last+offset (< 2*MAX_CH) never overflows.
    localparam int CAND_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Round-robin search: first set bit of pend starting at last+1, wrapping mod n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0] pend,
        input logic [IDX_W-1:0]  last,
        input logic [CAND_W-1:0] n
    );
        rr_pick_t          res;
        logic [CAND_W-1:0] cand;
        res.valid = 1'b0;
        res.idx   = {IDX_W{1'b0}};
        for (int k = 1; k <= MAX_CH; k++) begin
            cand = {1'b0, last} + CAND_W'(k);
            // last < n and k <= n, so a single subtraction completes the wrap.
            if (cand >= n) begin
                cand = cand - n;
            end else begin
                cand = cand;
            end
            if (!res.valid && (CAND_W'(k) <= n) && pend[cand[IDX_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[IDX_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/oneshot_edge_sync.sv
// Three-flop synchronizer for one asynchronous trigger plus rising-edge detect.
module oneshot_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rise
);

    // stage_r[0] is the metastability catcher; [2:1] are stable history.
    logic [2:0] stage_r;

    // Shift the raw trigger through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= 3'b000;
        end else begin
            stage_r <= {stage_r[1:0], trig};
        end
    end

    // Older sample low, newer sample high: a rising edge.
    assign rise = (stage_r[2:1] == 2'b01);

endmodule

// File: rtl/oneshot_arbiter.sv
// Round-robin arbiter sharing one fixed-length pulse timer between
// CHANNELS edge-triggered requesters, with a forced low gap between pulses.
module oneshot_arbiter
    import oneshot_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 10,
    parameter int GAP_LEN   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] trig,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] pending,
    output logic                busy,
    output logic [CHANNELS-1:0] overrun
);

    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
    // Unused when GAP_LEN is 0; kept in range so it never wraps.
    localparam logic [CNT_W-1:0] GAP_RELOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_RESET   = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] ONEHOT0   = {{(CHANNELS-1){1'b0}}, 1'b1};

    state_t              state_r,   state_next_s;
    logic [CNT_W-1:0]    cnt_r,     cnt_next_s;
    logic [CHANNELS-1:0] pulse_r,   pulse_next_s;
    logic [CHANNELS-1:0] pending_r, pending_next_s;
    logic [CHANNELS-1:0] overrun_r, overrun_next_s;
    logic                busy_r,    busy_next_s;
    logic [IDX_W-1:0]    last_grant_r, last_next_s;
    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] grant_mask_s;
    rr_pick_t            pick_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_sync
        oneshot_edge_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .trig  (trig[i]),
            .rise  (rise_s[i])
        );
    end

    // Next-state, counter, grant and request-queue logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pulse_next_s = pulse_r;
        last_next_s  = last_grant_r;
        grant_mask_s = {CHANNELS{1'b0}};
        pick_s       = rr_pick(MAX_CH'(pending_r), last_grant_r, CAND_W'(CHANNELS));

        case (state_r)
            ST_IDLE: begin
                if (enable && pick_s.valid) begin
                    grant_mask_s = ONEHOT0 << pick_s.idx;
                    pulse_next_s = ONEHOT0 << pick_s.idx;
                    cnt_next_s   = PULSE_RELOAD;
                    last_next_s  = pick_s.idx;
                    state_next_s = ST_PULSE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_next_s = cnt_r - CNT_W'(1'b1);
                end else begin
                    pulse_next_s = {CHANNELS{1'b0}};
                    if (GAP_LEN > 0) begin
                        cnt_next_s   = GAP_RELOAD;
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_next_s = cnt_r - CNT_W'(1'b1);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                pulse_next_s = {CHANNELS{1'b0}};
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase

        // A new edge re-queues even the channel being granted this cycle;
        // only an edge on a request that survives this cycle is an overrun.
        pending_next_s = (pending_r & ~grant_mask_s) | rise_s;
        overrun_next_s = rise_s & pending_r & ~grant_mask_s;
        busy_next_s    = (state_next_s != ST_IDLE);
    end

    // Arbiter state, timer, outputs and request queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            pulse_r      <= {CHANNELS{1'b0}};
            pending_r    <= {CHANNELS{1'b0}};
            overrun_r    <= {CHANNELS{1'b0}};
            busy_r       <= 1'b0;
            last_grant_r <= LAST_RESET;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            pulse_r      <= pulse_next_s;
            pending_r    <= pending_next_s;
            overrun_r    <= overrun_next_s;
            busy_r       <= busy_next_s;
            last_grant_r <= last_next_s;
        end
    end

    assign pulse   = pulse_r;
    assign pending = pending_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: doc/oneshot_arbiter.md
# oneshot_arbiter

Shares a single pulse-length timer between CHANNELS trigger inputs. Each input's rising edge queues a request. A round-robin scheduler then emits one fixed-length pulse at a time on the matching output, with a programmable low gap between pulses. It sits between asynchronous trigger sources (pins, counters) and actuators that must never fire simultaneously, e.g. solenoids on a shared supply.

## Interface
- CHANNELS, 4: number of requesters, 2..16.
- PULSE_LEN, 10: pulse high time in clk cycles, ≥1.
- GAP_LEN, 2: forced all-low cycles after each pulse, ≥0.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high allows new grants; low freezes arbitration only.
- trig  in  CHANNELS  per-channel trigger, asynchronous, rising-edge sensitive.
- pulse  out  CHANNELS  one-hot-or-zero pulse outputs, registered.
- pending  out  CHANNELS  queued, not-yet-granted requests.
- busy  out  1  high in PULSE or GAP.
- overrun  out  CHANNELS  one-cycle strobe: an edge arrived while that channel was already pending (request dropped).

## Operation
- Per channel, a 3-FF shift register samples trig; edge = stage[2:1]==2'b01.
- Edge sets pending[i]. If pending[i] is already 1, the edge is dropped and overrun[i] pulses for 1 cycle.
- FSM states IDLE, PULSE, GAP:
  - IDLE: if enable && |pending, grant the first pending channel searching from last_grant+1 upward (wrap mod CHANNELS). Then clear pending[g], set pulse to onehot(g), load cnt=PULSE_LEN-1, store last_grant=g, go to PULSE.
  - PULSE: while cnt≠0, decrement. At cnt==0, pulse<=0. If GAP_LEN>0, load cnt=GAP_LEN-1 and go to GAP; else go to IDLE.
  - GAP: decrement; at cnt==0 go to IDLE.
- Same-cycle edge and grant on the same channel: the grant clears the old request and the edge sets pending again (set wins). No overrun is reported.
- An edge on the channel currently pulsing simply queues a new request.
- enable low in PULSE/GAP: the current pulse and gap complete. In IDLE no grant is made. Pending bits keep accumulating.
- Counter width is $clog2(max(PULSE_LEN,GAP_LEN)+1) bits, unsigned, no wrap (always reloaded before reaching 0 again).

## Timing
- Reset values: pulse=0, pending=0, busy=0, overrun=0, state=IDLE, last_grant=CHANNELS-1 (so channel 0 has first priority), sync FFs=0.
- Reset assertion mid-pulse drops pulse combinationally-asynchronously to 0 and discards all pending requests.
- Latency: trig sampled high at edge k → pending set after edge k+2 → pulse high after edge k+3 (if IDLE and enabled).
- pulse is high for exactly PULSE_LEN cycles and is followed by exactly GAP_LEN low cycles. IDLE costs 1 further cycle, so back-to-back pulse spacing is GAP_LEN+1 low cycles.
- busy is high for PULSE_LEN+GAP_LEN cycles per grant, aligned with pulse rising.
- overrun is asserted the cycle after the edge-detect condition, i.e. aligned with when pending would have been set.

## Structure
- Shared package oneshot_pkg holds the state enum type (IDLE/PULSE/GAP) and a round-robin helper function rr_pick(pending, last) returning the grant index and a valid flag.
- One sub-module, oneshot_edge_sync: a per-channel 3-FF synchronizer plus rising-edge detector, instantiated CHANNELS times via generate.
- The top level holds the pending register, FSM, counter and last_grant.

## Test plan
- Single request: CHANNELS=4, PULSE_LEN=10, GAP_LEN=2; raise trig[2] at edge 5. Expect pulse[2] high edges 8–17 (10 cycles), busy 12 cycles, pending[2] high only edge 7.
- Round robin: raise trig[0..3] together. Expect pulses in order 0,1,2,3, each 10 cycles, separated by 3 low cycles. A second burst starts from channel 0 again (last_grant=3).
- Overrun: double-edge trig[1] (two 2-cycle high pulses 4 cycles apart) while channel 0 is pulsing. Expect one overrun[1] strobe and exactly one pulse on channel 1.
- Set-wins: edge on channel 3 detected in the same cycle channel 3 is granted. Expect two pulses on channel 3 and no overrun.
- Enable gating: drop enable mid-pulse on channel 0 with channel 1 pending. Expect pulse 0 to finish its full 10 cycles, no channel 1 pulse until enable returns, then pulse 1 starts 1 cycle after enable rises.
- Reset mid-operation, plus GAP_LEN=0: assert rst_n low during PULSE. Expect all outputs 0 immediately and nothing pending after release. With GAP_LEN=0, back-to-back pulses are separated by exactly 1 low cycle.
